// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//
// Two-master arbiter that shares one single-outstanding memory port between an
// instruction-fetch master (if_*) and a load/store master (dm_*). Data requests
// normally win. A streak counter lets a waiting fetch through after MAX_STREAK
// consecutive data wins. A response that has not arrived within TIMEOUT wait
// cycles is completed locally with err = 1 and zero read data.
//
// Parameters
//   MAX_STREAK  consecutive data wins (with a fetch waiting) before fetch wins
//   TIMEOUT     response-wait cycles before a forced error response
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   if_req/if_addr            fetch request (held until if_gnt)
//   if_gnt                    fetch accepted (pulse, follows mem_gnt)
//   if_rvalid/if_rdata        fetch response (pulse)
//   dm_req/dm_we/dm_addr/
//   dm_wdata/dm_be            load/store request (held until dm_gnt)
//   dm_gnt                    data accepted (pulse, follows mem_gnt)
//   dm_rvalid/dm_rdata        data response for loads and stores (pulse)
//   err                       current response was forced by timeout
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be          registered request to shared memory
//   mem_gnt                   memory accepted the request
//   mem_rvalid/mem_rdata      memory response
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned MAX_STREAK = 4,
    parameter int unsigned TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        rstn,

    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,

    input  logic        dm_req,
    input  logic        dm_we,
    input  logic [31:0] dm_addr,
    input  logic [31:0] dm_wdata,
    input  logic [3:0]  dm_be,
    output logic        dm_gnt,
    output logic        dm_rvalid,
    output logic [31:0] dm_rdata,

    output logic        err,

    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    // Counter widths are kept at least one bit so degenerate parameter values
    // (0 or 1) still elaborate.
    localparam int unsigned STREAK_W = (MAX_STREAK < 2) ? 1 : $clog2(MAX_STREAK + 1);
    localparam int unsigned TMO_W    = (TIMEOUT < 2)    ? 1 : $clog2(TIMEOUT + 1);

    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_STREAK);
    localparam logic [TMO_W-1:0]    TMO_MAX    = TMO_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_IF,
        OWN_DM
    } owner_e;

    state_e                state_q,     state_d;
    owner_e                owner_q,     owner_d;
    logic [STREAK_W-1:0]   streak_q,    streak_d;
    logic [TMO_W-1:0]      tmo_q,       tmo_d;
    logic                  mem_req_q,   mem_req_d;
    logic                  mem_we_q,    mem_we_d;
    logic [31:0]           mem_addr_q,  mem_addr_d;
    logic [31:0]           mem_wdata_q, mem_wdata_d;
    logic [3:0]            mem_be_q,    mem_be_d;

    logic                  fetch_wins;
    logic                  tmo_hit;
    logic                  rsp_valid;
    logic                  rsp_err;
    logic [31:0]           rsp_data;

    // Fetch wins when it is the only requester, or when data has held the
    // port for MAX_STREAK consecutive wins while the fetch was waiting.
    always_comb begin
        fetch_wins = if_req && (!dm_req || (streak_q == STREAK_MAX));
    end

    // A real response in the same cycle as the timeout takes precedence.
    always_comb begin
        tmo_hit = (state_q == ST_RESP) && !mem_rvalid && (tmo_q == TMO_MAX);
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            streak_q    <= '0;
            tmo_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            streak_q    <= streak_d;
            tmo_q       <= tmo_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        streak_d    = streak_q;
        tmo_d       = tmo_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;

        unique case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    state_d   = ST_ADDR;
                    mem_req_d = 1'b1;
                    if (fetch_wins) begin
                        // Fetch is always a full-word read.
                        owner_d     = OWN_IF;
                        streak_d    = '0;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                        mem_wdata_d = '0;
                        mem_be_d    = '1;
                    end else begin
                        owner_d     = OWN_DM;
                        mem_we_d    = dm_we;
                        mem_addr_d  = dm_addr;
                        mem_wdata_d = dm_wdata;
                        mem_be_d    = dm_be;
                        // Streak only builds while a fetch is actually waiting.
                        if (!if_req) begin
                            streak_d = '0;
                        end else if (streak_q != STREAK_MAX) begin
                            streak_d = streak_q + STREAK_W'(1);
                        end
                    end
                end
            end

            ST_ADDR: begin
                if (mem_gnt) begin
                    state_d   = ST_RESP;
                    mem_req_d = 1'b0;
                    tmo_d     = '0;
                end
            end

            ST_RESP: begin
                if (mem_rvalid || tmo_hit) begin
                    state_d = ST_IDLE;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: grant and response are routed to the owner only. Response data
    // is zero whenever no response is presented, which also keeps it zero
    // throughout reset.
    // -------------------------------------------------------------------------
    always_comb begin
        rsp_valid = 1'b0;
        rsp_err   = 1'b0;
        rsp_data  = '0;
        if_gnt    = 1'b0;
        dm_gnt    = 1'b0;
        if_rvalid = 1'b0;
        dm_rvalid = 1'b0;
        if_rdata  = '0;
        dm_rdata  = '0;
        err       = 1'b0;

        if ((state_q == ST_ADDR) && mem_gnt) begin
            if (owner_q == OWN_DM) begin
                dm_gnt = 1'b1;
            end else begin
                if_gnt = 1'b1;
            end
        end

        if (state_q == ST_RESP) begin
            if (mem_rvalid) begin
                rsp_valid = 1'b1;
                rsp_data  = mem_rdata;
            end else if (tmo_hit) begin
                rsp_valid = 1'b1;
                rsp_err   = 1'b1;
            end
        end

        if (rsp_valid) begin
            err = rsp_err;
            if (owner_q == OWN_DM) begin
                dm_rvalid = 1'b1;
                dm_rdata  = rsp_data;
            end else begin
                if_rvalid = 1'b1;
                if_rdata  = rsp_data;
            end
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned MAX_STREAK = 4;
    localparam int unsigned TIMEOUT    = 255;

    logic        clk = 1'b0;
    logic        rstn;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        dm_req, dm_we;
    logic [31:0] dm_addr, dm_wdata;
    logic [3:0]  dm_be;
    logic        dm_gnt, dm_rvalid;
    logic [31:0] dm_rdata;
    logic        err;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt, mem_rvalid;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    mem_arbiter #(.MAX_STREAK(MAX_STREAK), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_be(dm_be), .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .err(err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_gnt(mem_gnt),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    logic [138:0] all_outs;
    assign all_outs = {if_gnt, if_rvalid, if_rdata, dm_gnt, dm_rvalid, dm_rdata, err,
                       mem_req, mem_we, mem_addr, mem_wdata, mem_be};

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } drv_t;

    typedef struct {
        bit          is_dm;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          req_cycles;
    } exp_req_t;

    typedef struct {
        bit          is_dm;
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_rsp_t;

    typedef struct {
        bit          none;
        logic [31:0] data;
    } mem_rsp_t;

    drv_t     if_q[$];
    drv_t     dm_q[$];
    exp_req_t exp_req_q[$];
    exp_rsp_t exp_rsp_q[$];
    mem_rsp_t mem_rsp_q[$];

    int checks = 0;
    int passes = 0;
    int cyc = 0;
    int gnt_delay = 0;
    bit stray_en = 1'b0;
    int req_cyc = 0;
    int last_gnt = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- scoreboard pushes ----------------
    task automatic exp_req(input bit is_dm, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] be, input int rc);
        exp_req_t e;
        e.is_dm = is_dm; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be; e.req_cycles = rc;
        exp_req_q.push_back(e);
    endtask

    task automatic exp_rsp(input bit is_dm, input logic [31:0] rdata, input logic e_err, input int lat);
        exp_rsp_t r;
        r.is_dm = is_dm; r.rdata = rdata; r.err = e_err; r.lat = lat;
        exp_rsp_q.push_back(r);
    endtask

    task automatic mem_resp(input bit none, input logic [31:0] data);
        mem_rsp_t m;
        m.none = none; m.data = data;
        mem_rsp_q.push_back(m);
    endtask

    task automatic add_if(input logic [31:0] addr);
        drv_t d;
        d.we = 1'b0; d.addr = addr; d.wdata = '0; d.be = '1;
        if_q.push_back(d);
    endtask

    task automatic add_dm(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be);
        drv_t d;
        d.we = we; d.addr = addr; d.wdata = wdata; d.be = be;
        dm_q.push_back(d);
    endtask

    task automatic wait_drain(input int limit);
        int n;
        n = 0;
        while ((exp_req_q.size() + exp_rsp_q.size() + if_q.size() + dm_q.size()) != 0 && n < limit) begin
            @(negedge clk);
            n++;
        end
        if ((exp_req_q.size() + exp_rsp_q.size()) != 0)
            chk("drain_timeout", 160'(exp_req_q.size() + exp_rsp_q.size()), '0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- requesters ----------------
    initial begin : if_driver
        drv_t it;
        int   n;
        if_req = 1'b0;
        if_addr = '0;
        @(posedge clk); #1;
        forever begin
            if (if_q.size() == 0) begin
                if_req = 1'b0;
                @(posedge clk); #1;
            end else begin
                it = if_q.pop_front();
                if_req = 1'b1;
                if_addr = it.addr;
                n = 0;
                do begin @(negedge clk); n++; end while (!if_gnt && n < 1000);
                if (!if_gnt) chk("if_gnt_wait", 160'(if_gnt), 160'(1));
                @(posedge clk); #1;
            end
        end
    end

    initial begin : dm_driver
        drv_t it;
        int   n;
        dm_req = 1'b0; dm_we = 1'b0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
        @(posedge clk); #1;
        forever begin
            if (dm_q.size() == 0) begin
                dm_req = 1'b0;
                @(posedge clk); #1;
            end else begin
                it = dm_q.pop_front();
                dm_req = 1'b1;
                dm_we = it.we; dm_addr = it.addr; dm_wdata = it.wdata; dm_be = it.be;
                n = 0;
                do begin @(negedge clk); n++; end while (!dm_gnt && n < 1000);
                if (!dm_gnt) chk("dm_gnt_wait", 160'(dm_gnt), 160'(1));
                @(posedge clk); #1;
            end
        end
    end

    // ---------------- memory model ----------------
    initial begin : mem_model
        int       wcnt;
        bit       granted;
        mem_rsp_t r;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        wcnt = 0; granted = 1'b0;
        forever begin
            @(posedge clk); #1;
            mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
            if (!rstn) begin
                wcnt = 0; granted = 1'b0;
            end else if (granted) begin
                granted = 1'b0;
                if (mem_rsp_q.size() != 0) begin
                    r = mem_rsp_q.pop_front();
                    if (!r.none) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = r.data;
                    end
                end
            end else if (mem_req) begin
                if (wcnt >= gnt_delay) begin
                    mem_gnt = 1'b1; granted = 1'b1; wcnt = 0;
                end else begin
                    // Spurious response while the request is still pending.
                    if (stray_en && wcnt == 2) begin
                        mem_rvalid = 1'b1;
                        mem_rdata = 32'hBAD0_BAD0;
                    end
                    wcnt++;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        exp_req_t er;
        exp_rsp_t rs;
        forever begin
            @(negedge clk);
            if (!rstn) req_cyc = 0;
            if (mem_req) begin
                req_cyc++;
                if (exp_req_q.size() == 0) begin
                    chk("unexpected_mem_req", 160'(mem_req), '0);
                end else begin
                    er = exp_req_q[0];
                    chk("mem_payload", 160'({mem_we, mem_addr, mem_wdata, mem_be}),
                        160'({er.we, er.addr, er.wdata, er.be}));
                    if (mem_gnt) begin
                        chk("gnt_owner", 160'({if_gnt, dm_gnt}), er.is_dm ? 160'(1) : 160'(2));
                        chk("req_cycles", 160'(req_cyc), 160'(er.req_cycles));
                        void'(exp_req_q.pop_front());
                        last_gnt = cyc;
                        req_cyc = 0;
                    end
                end
            end
            if ((if_gnt || dm_gnt) && !(mem_req && mem_gnt))
                chk("stray_gnt", 160'({if_gnt, dm_gnt}), '0);
            if (err && !(if_rvalid || dm_rvalid))
                chk("stray_err", 160'(err), '0);
            if (if_rvalid || dm_rvalid) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("unexpected_rvalid", 160'({if_rvalid, dm_rvalid}), '0);
                end else begin
                    rs = exp_rsp_q.pop_front();
                    chk("rsp_owner", 160'({if_rvalid, dm_rvalid}), rs.is_dm ? 160'(1) : 160'(2));
                    chk("rsp_data", 160'(rs.is_dm ? dm_rdata : if_rdata), 160'(rs.rdata));
                    chk("rsp_err", 160'(err), 160'(rs.err));
                    if (rs.lat >= 0) chk("rsp_latency", 160'(cyc - last_gnt), 160'(rs.lat));
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached, actual running required finished");
        $fatal(1);
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        int n;
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", 160'(all_outs), '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("post_reset_idle", 160'(all_outs), '0);

        // Single fetch, immediate grant, response one cycle later.
        exp_req(1'b0, 1'b0, 32'h0000_0100, '0, 4'hF, 1);
        mem_resp(1'b0, 32'h0000_0013);
        exp_rsp(1'b0, 32'h0000_0013, 1'b0, 1);
        add_if(32'h0000_0100);
        wait_drain(50);

        // Simultaneous requests: store wins, fetch follows.
        exp_req(1'b1, 1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011, 1);
        mem_resp(1'b0, 32'h0000_5A5A);
        exp_rsp(1'b1, 32'h0000_5A5A, 1'b0, 1);
        exp_req(1'b0, 1'b0, 32'h0000_0104, '0, 4'hF, 1);
        mem_resp(1'b0, 32'h0010_0093);
        exp_rsp(1'b0, 32'h0010_0093, 1'b0, 1);
        add_dm(1'b1, 32'h0000_0200, 32'hDEAD_BEEF, 4'b0011);
        add_if(32'h0000_0104);
        wait_drain(50);

        // Starvation guard: D D D D F D D F.
        for (int i = 0; i < 4; i++) begin
            exp_req(1'b1, 1'b0, 32'h0000_0400 + 32'(4 * i), '0, 4'hF, 1);
            mem_resp(1'b0, 32'hD000_0000 + 32'(i));
            exp_rsp(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1);
        end
        exp_req(1'b0, 1'b0, 32'h0000_0800, '0, 4'hF, 1);
        mem_resp(1'b0, 32'hF000_0000);
        exp_rsp(1'b0, 32'hF000_0000, 1'b0, 1);
        for (int i = 4; i < 6; i++) begin
            exp_req(1'b1, 1'b0, 32'h0000_0400 + 32'(4 * i), '0, 4'hF, 1);
            mem_resp(1'b0, 32'hD000_0000 + 32'(i));
            exp_rsp(1'b1, 32'hD000_0000 + 32'(i), 1'b0, 1);
        end
        exp_req(1'b0, 1'b0, 32'h0000_0804, '0, 4'hF, 1);
        mem_resp(1'b0, 32'hF000_0001);
        exp_rsp(1'b0, 32'hF000_0001, 1'b0, 1);
        for (int i = 0; i < 6; i++) add_dm(1'b0, 32'h0000_0400 + 32'(4 * i), '0, 4'hF);
        add_if(32'h0000_0800);
        add_if(32'h0000_0804);
        wait_drain(100);

        // Grant withheld 5 cycles (mem_req high 6), with a stray response in ADDR.
        gnt_delay = 5;
        stray_en = 1'b1;
        exp_req(1'b1, 1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 4'b1100, 6);
        mem_resp(1'b0, 32'h5555_AAAA);
        exp_rsp(1'b1, 32'h5555_AAAA, 1'b0, 1);
        add_dm(1'b1, 32'h0000_0500, 32'h0BAD_CAFE, 4'b1100);
        wait_drain(50);
        gnt_delay = 0;
        stray_en = 1'b0;

        // Timeout: no response; forced error TIMEOUT+1 cycles after the grant.
        exp_req(1'b0, 1'b0, 32'h0000_0600, '0, 4'hF, 1);
        mem_resp(1'b1, '0);
        exp_rsp(1'b0, 32'h0000_0000, 1'b1, int'(TIMEOUT) + 1);
        add_if(32'h0000_0600);
        wait_drain(400);

        // Reset during RESP aborts silently; a later fetch completes normally.
        exp_req(1'b0, 1'b0, 32'h0000_0700, '0, 4'hF, 1);
        mem_resp(1'b1, '0);
        add_if(32'h0000_0700);
        n = 0;
        while (exp_req_q.size() != 0 && n < 50) begin @(negedge clk); n++; end
        chk("abort_txn_granted", 160'(exp_req_q.size()), '0);
        repeat (3) @(negedge clk);
        rstn = 1'b0;
        #1;
        chk("midreset_outputs", 160'(all_outs), '0);
        @(negedge clk);
        chk("midreset_outputs_hold", 160'(all_outs), '0);
        @(posedge clk); #1;
        rstn = 1'b1;
        @(negedge clk);
        chk("after_abort_idle", 160'(all_outs), '0);
        exp_req(1'b0, 1'b0, 32'h0000_0704, '0, 4'hF, 1);
        mem_resp(1'b0, 32'h1234_5678);
        exp_rsp(1'b0, 32'h1234_5678, 1'b0, 1);
        add_if(32'h0000_0704);
        wait_drain(50);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_STREAK, default 4, SHALL set the number of consecutive data grants after which a waiting fetch wins.
REQ-002 Parameter TIMEOUT, default 255, SHALL set the maximum number of response-wait cycles before an error response is forced.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge only.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 if_req  input  1  instruction fetch request; held by the requester until if_gnt.
REQ-006 if_addr  input  32  fetch byte address.
REQ-007 if_gnt  output  1  fetch request accepted, one-cycle pulse.
REQ-008 if_rvalid  output  1  fetch response valid, one-cycle pulse.
REQ-009 if_rdata  output  32  fetch read data, valid with if_rvalid.
REQ-010 dm_req  input  1  load/store request; held by the requester until dm_gnt.
REQ-011 dm_we  input  1  1 = store, 0 = load.
REQ-012 dm_addr  input  32  data byte address.
REQ-013 dm_wdata  input  32  store data.
REQ-014 dm_be  input  4  store byte enables.
REQ-015 dm_gnt  output  1  data request accepted, one-cycle pulse.
REQ-016 dm_rvalid  output  1  data response valid (loads and stores), one-cycle pulse.
REQ-017 dm_rdata  output  32  load data, valid with dm_rvalid.
REQ-018 err  output  1  response was forced by timeout; valid with if_rvalid/dm_rvalid.
REQ-019 mem_req, mem_we, mem_addr[31:0], mem_wdata[31:0], mem_be[3:0]  outputs  shared memory request.
REQ-020 mem_gnt  input  1  memory accepted the request.
REQ-021 mem_rvalid  input  1  memory response valid.
REQ-022 mem_rdata  input  32  memory read data.

Function
REQ-023 The FSM SHALL have states IDLE, ADDR and RESP, with at most one transaction outstanding.
REQ-024 In IDLE with any request, the block SHALL latch the winner (owner) and its payload into the mem_* registers and enter ADDR on the next edge.
REQ-025 Arbitration: data SHALL win over fetch, except when streak == MAX_STREAK and if_req = 1, in which case fetch SHALL win.
REQ-026 streak SHALL increment (saturating at MAX_STREAK) on each data win while if_req = 1, and SHALL clear on any fetch win or when a data win occurs with if_req = 0.
REQ-027 In ADDR, mem_req SHALL be 1 and the mem_* payload SHALL stay stable until mem_gnt.
REQ-028 The owner's gnt SHALL equal mem_gnt combinationally in ADDR; on mem_gnt the FSM SHALL clear mem_req and enter RESP.
REQ-029 In RESP, mem_rvalid SHALL pulse the owner's rvalid in the same cycle, with rdata = mem_rdata and err = 0; the FSM SHALL return to IDLE.
REQ-030 The timeout counter SHALL clear on entering RESP and increment each RESP cycle without mem_rvalid.
REQ-031 When the counter reaches TIMEOUT, the owner's rvalid SHALL pulse with err = 1 and rdata = 32'h0, and the FSM SHALL enter IDLE.
REQ-032 A mem_rvalid arriving in IDLE or ADDR SHALL be ignored.
REQ-033 The minimum transaction SHALL take 3 cycles (IDLE, ADDR, RESP), so the back-to-back rate is 1 transaction per 3 cycles.
REQ-034 The non-owner SHALL never see gnt or rvalid; if_rvalid and dm_rvalid SHALL never both be 1 in the same cycle.
REQ-035 A requester deasserting req before gnt is a protocol violation; the latched transaction SHALL still complete.

Reset
REQ-036 While rstn = 0, the block SHALL hold: state IDLE, streak 0, timeout counter 0, owner fetch.
REQ-037 While rstn = 0, all outputs SHALL be 0, including mem_* payload and rdata.
REQ-038 Reset asserted mid-transaction SHALL abort it without any gnt or rvalid; the first request after reset release SHALL start in IDLE.

Verification
REQ-039 Single fetch: if_req, if_addr = 0x100, mem_gnt immediate, mem_rvalid with rdata 0x00000013 one cycle later -> mem_req high 1 cycle, then if_gnt pulse, then if_rvalid with if_rdata = 0x13.
REQ-040 Simultaneous if_req and dm_req (store 0xDEADBEEF, be = 4'b0011, addr 0x200) -> data served first with mem_we = 1, mem_be = 0011, mem_wdata = 0xDEADBEEF; fetch is served next.
REQ-041 Starvation: dm_req and if_req held continuously, MAX_STREAK = 4 -> grant order D, D, D, D, F, D, ...
REQ-042 mem_gnt withheld 5 cycles -> mem_req and the payload stay stable for all 5 cycles; exactly one dm_gnt.
REQ-043 Timeout: mem_rvalid never arrives, TIMEOUT = 255 -> exactly 255 RESP cycles, then owner rvalid with err = 1 and rdata = 0, then IDLE.
REQ-044 rstn pulsed low during RESP -> no rvalid, all outputs 0, state IDLE; a new fetch afterwards completes normally.
